// File: rtl/power_stim_gen.sv
// LFSR stimulus generator with MISR response signature for power characterisation runs.
// Define POWER_STIM_TOGGLE_CNT_EN to build the resp/stim toggle counters.
module power_stim_gen #(
    parameter logic [15:0] NUM_VEC = 16'd256,
    parameter logic [15:0] SEED    = 16'h0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  stim,
    input  logic        resp,
    output logic        busy,
    output logic        done,
    output logic [15:0] sig,
    output logic [15:0] resp_toggles,
    output logic [15:0] stim_toggles
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q;
    logic [15:0] lfsr_q;
    logic [15:0] vec_cnt_q;
    logic [15:0] lfsr_next;
    logic [15:0] sig_next;
    logic        last_sample;

    always_comb begin
        lfsr_next   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        sig_next    = {sig[14:0], sig[15] ^ sig[13] ^ sig[12] ^ sig[10] ^ resp};
        last_sample = (vec_cnt_q == NUM_VEC - 16'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            stim      <= 4'h0;
            lfsr_q    <= 16'h0000;
            vec_cnt_q <= 16'h0000;
            sig       <= 16'h0000;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        lfsr_q    <= SEED_EFF;
                        stim      <= SEED_EFF[3:0];
                        vec_cnt_q <= 16'h0000;
                        sig       <= 16'h0000;
                        if (NUM_VEC == 16'h0000) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else begin
                            state_q <= StRun;
                            busy    <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    sig <= sig_next;
                    if (last_sample) begin
                        // Final sample: stim stays on the last vector through DONE and IDLE.
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        lfsr_q    <= lfsr_next;
                        stim      <= lfsr_next[3:0];
                        vec_cnt_q <= vec_cnt_q + 16'd1;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

`ifdef POWER_STIM_TOGGLE_CNT_EN
    logic        start_acc;
    logic        resp_prev_q;
    logic [3:0]  stim_diff;
    logic [2:0]  stim_flips;
    logic [16:0] stim_sum;

    always_comb begin
        start_acc  = (state_q == StIdle) && start;
        stim_diff  = stim ^ lfsr_next[3:0];
        stim_flips = {2'b00, stim_diff[0]} + {2'b00, stim_diff[1]} +
                     {2'b00, stim_diff[2]} + {2'b00, stim_diff[3]};
        stim_sum   = {1'b0, stim_toggles} + {14'h0000, stim_flips};
    end

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            resp_prev_q  <= 1'b0;
            resp_toggles <= 16'h0000;
            stim_toggles <= 16'h0000;
        end else if (state_q == StRun) begin
            resp_prev_q <= resp;
            // vec_cnt_q == 0 marks the first sample, which has no predecessor.
            if ((vec_cnt_q != 16'h0000) && (resp != resp_prev_q) &&
                (resp_toggles != 16'hFFFF)) begin
                resp_toggles <= resp_toggles + 16'd1;
            end
            if (!last_sample) begin
                stim_toggles <= stim_sum[16] ? 16'hFFFF : stim_sum[15:0];
            end
        end
    end
`else
    assign resp_toggles = 16'h0000;
    assign stim_toggles = 16'h0000;
`endif

endmodule

// File: tb/tb_power_stim_gen.sv
// Directed plus randomized bench for power_stim_gen; three instances cover the
// nominal, empty and random-response configurations.
module tb_power_stim_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start = 1'b0, resp = 1'b0;
    logic [3:0]  stim;
    logic        busy, done;
    logic [15:0] sig, resp_toggles, stim_toggles;

    logic        start_e = 1'b0;
    logic [3:0]  stim_e;
    logic        busy_e, done_e;
    logic [15:0] sig_e, rt_e, st_e;

    logic        start_r = 1'b0, resp_r = 1'b0;
    logic [3:0]  stim_r;
    logic        busy_r, done_r;
    logic [15:0] sig_r, rt_r, st_r;

    int errors = 0;
    int checks = 0;

`ifdef POWER_STIM_TOGGLE_CNT_EN
    localparam bit TogEn = 1'b1;
`else
    localparam bit TogEn = 1'b0;
`endif

    power_stim_gen #(.NUM_VEC(16'd4), .SEED(16'h0001)) dut (
        .clk(clk), .rst(rst), .start(start), .stim(stim), .resp(resp),
        .busy(busy), .done(done), .sig(sig),
        .resp_toggles(resp_toggles), .stim_toggles(stim_toggles)
    );

    power_stim_gen #(.NUM_VEC(16'd0), .SEED(16'h0000)) dut_e (
        .clk(clk), .rst(rst), .start(start_e), .stim(stim_e), .resp(1'b1),
        .busy(busy_e), .done(done_e), .sig(sig_e),
        .resp_toggles(rt_e), .stim_toggles(st_e)
    );

    power_stim_gen #(.NUM_VEC(16'd20), .SEED(16'h9C35)) dut_r (
        .clk(clk), .rst(rst), .start(start_r), .stim(stim_r), .resp(resp_r),
        .busy(busy_r), .done(done_r), .sig(sig_r),
        .resp_toggles(rt_r), .stim_toggles(st_r)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] v, input logic r);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10] ^ r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One 4-vector run on dut; pat[k] is the response presented for sample k.
    task automatic nominal_run(input logic [3:0] pat, input logic [15:0] esig,
                               input logic [15:0] ert);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("nom_busy", {15'h0, busy}, 16'd1);
            chk("nom_done_low", {15'h0, done}, 16'd0);
            chk("nom_stim", {12'h0, stim}, 16'(1 << k));
            resp = pat[k];
            tick();
        end
        chk("nom_busy_end", {15'h0, busy}, 16'd0);
        chk("nom_done", {15'h0, done}, 16'd1);
        chk("nom_sig", sig, esig);
        chk("nom_resp_tog", resp_toggles, TogEn ? ert : 16'd0);
        chk("nom_stim_tog", stim_toggles, TogEn ? 16'd6 : 16'd0);
        chk("nom_stim_hold", {12'h0, stim}, 16'd8);
        tick();
        chk("nom_done_pulse", {15'h0, done}, 16'd0);
        chk("nom_sig_stable", sig, esig);
        chk("nom_stim_idle", {12'h0, stim}, 16'd8);
    endtask

    initial begin
        logic [15:0] lf, nl, es;
        int rt, st;
        logic r, prev;

        tick();
        tick();
        chk("rst_stim", {12'h0, stim}, 16'd0);
        chk("rst_busy", {15'h0, busy}, 16'd0);
        chk("rst_done", {15'h0, done}, 16'd0);
        chk("rst_sig", sig, 16'd0);
        chk("rst_resp_tog", resp_toggles, 16'd0);
        chk("rst_stim_tog", stim_toggles, 16'd0);
        chk("rst_e_done", {15'h0, done_e}, 16'd0);

        // Reset wins over a simultaneous start.
        start = 1'b1;
        tick();
        chk("rst_prio_busy", {15'h0, busy}, 16'd0);
        chk("rst_prio_stim", {12'h0, stim}, 16'd0);
        rst = 1'b0;
        start = 1'b0;
        tick();
        chk("idle_busy", {15'h0, busy}, 16'd0);

        nominal_run(4'b1111, 16'h000F, 16'd0);
        nominal_run(4'b1010, 16'h0005, 16'd3);

        // Start held high for the whole run and beyond.
        start = 1'b1;
        resp = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("hold_busy", {15'h0, busy}, 16'd1);
            chk("hold_done_low", {15'h0, done}, 16'd0);
            tick();
        end
        chk("hold_done", {15'h0, done}, 16'd1);
        chk("hold_stim_tog", stim_toggles, TogEn ? 16'd6 : 16'd0);
        tick();
        chk("hold_idle_done", {15'h0, done}, 16'd0);
        chk("hold_idle_busy", {15'h0, busy}, 16'd0);
        tick();
        start = 1'b0;
        chk("restart_busy", {15'h0, busy}, 16'd1);
        chk("restart_sig", sig, 16'd0);
        chk("restart_stim", {12'h0, stim}, 16'd1);
        chk("restart_resp_tog", resp_toggles, 16'd0);
        chk("restart_stim_tog", stim_toggles, 16'd0);
        for (int k = 0; k < 4; k++) tick();
        chk("restart_done", {15'h0, done}, 16'd1);
        chk("restart_sig_end", sig, 16'h000F);
        tick();
        chk("restart_done_pulse", {15'h0, done}, 16'd0);

        // Reset in the second RUN cycle aborts the run.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("mid_sig_before", sig, 16'd1);
        chk("mid_stim_before", {12'h0, stim}, 16'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", {15'h0, busy}, 16'd0);
        chk("abort_done", {15'h0, done}, 16'd0);
        chk("abort_stim", {12'h0, stim}, 16'd0);
        chk("abort_sig", sig, 16'd0);
        chk("abort_resp_tog", resp_toggles, 16'd0);
        chk("abort_stim_tog", stim_toggles, 16'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_no_done", {15'h0, done}, 16'd0);
            chk("abort_no_busy", {15'h0, busy}, 16'd0);
        end

        // Empty run with a zero seed.
        start_e = 1'b1;
        tick();
        start_e = 1'b0;
        chk("empty_done", {15'h0, done_e}, 16'd1);
        chk("empty_busy", {15'h0, busy_e}, 16'd0);
        chk("empty_sig", sig_e, 16'd0);
        chk("empty_stim_seed", {12'h0, stim_e}, 16'd1);
        chk("empty_resp_tog", rt_e, 16'd0);
        chk("empty_stim_tog", st_e, 16'd0);
        tick();
        chk("empty_done_pulse", {15'h0, done_e}, 16'd0);
        chk("empty_busy_after", {15'h0, busy_e}, 16'd0);

        // Random responses and stray start requests on a 20-vector run.
        for (int run = 0; run < 3; run++) begin
            repeat ($urandom_range(0, 3)) tick();
            lf = 16'h9C35;
            es = 16'h0000;
            rt = 0;
            st = 0;
            prev = 1'b0;
            start_r = 1'b1;
            tick();
            for (int k = 0; k < 20; k++) begin
                start_r = 1'($urandom);
                chk("rnd_busy", {15'h0, busy_r}, 16'd1);
                chk("rnd_stim", {12'h0, stim_r}, {12'h0, lf[3:0]});
                r = 1'($urandom);
                resp_r = r;
                es = misr_step(es, r);
                if (k > 0 && r != prev) rt++;
                prev = r;
                if (k < 19) begin
                    nl = lfsr_step(lf);
                    st += $countones(lf[3:0] ^ nl[3:0]);
                    lf = nl;
                end
                tick();
            end
            start_r = 1'b0;
            chk("rnd_done", {15'h0, done_r}, 16'd1);
            chk("rnd_busy_end", {15'h0, busy_r}, 16'd0);
            chk("rnd_sig", sig_r, es);
            chk("rnd_resp_tog", rt_r, TogEn ? 16'(rt) : 16'd0);
            chk("rnd_stim_tog", st_r, TogEn ? 16'(st) : 16'd0);
            chk("rnd_stim_hold", {12'h0, stim_r}, {12'h0, lf[3:0]});
            tick();
            chk("rnd_done_pulse", {15'h0, done_r}, 16'd0);
            chk("rnd_sig_stable", sig_r, es);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
